gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and code width in bits; legal range 1..32.
REQ-002 clk    input   1      single clock; all state changes on rising edge.
REQ-003 rst    input   1      reset, synchronous, active-high.
REQ-004 en     input   1      count enable; one step per cycle while high.
REQ-005 up     input   1      direction: 1 = increment, 0 = decrement (binary sense).
REQ-006 load   input   1      synchronous load strobe.
REQ-007 load_bin  input  WIDTH  binary value to load; encoded to Gray on load.
REQ-008 gray   output  WIDTH  registered Gray-code count (the state).
REQ-009 bin    output  WIDTH  binary equivalent of gray; combinational decode of the gray register.
REQ-010 wrap   output  1      registered one-cycle pulse marking a wrap-around step.

Function
REQ-011 State SHALL be held only as a Gray-code register; no separate binary count register.
REQ-012 Encoding SHALL be reflected binary: gray = b XOR (b >> 1); decoding: bin[WIDTH-1] = gray[WIDTH-1], bin[i] = bin[i+1] XOR gray[i].
REQ-013 Next state SHALL be computed as decode -> binary +1 or -1 (modulo 2^WIDTH) -> encode.
REQ-014 Priority per cycle SHALL be rst > load > en > hold.
REQ-015 load high: gray <= encode(load_bin) next edge; en and up ignored that cycle; wrap <= 0.
REQ-016 en high, load low: gray advances one step in direction up; latency one cycle.
REQ-017 en low, load low: gray and bin hold; wrap <= 0.
REQ-018 Consecutive counted values SHALL differ in exactly one gray bit, including across wrap.
REQ-019 wrap <= 1 for the cycle following a counted step from binary 2^WIDTH-1 to 0 (up) or 0 to 2^WIDTH-1 (down); else 0.
REQ-020 A load of any value, including 0 or 2^WIDTH-1, SHALL NOT assert wrap.
REQ-021 Changing up while en is high SHALL take effect on the very next step; no dead cycle.
REQ-022 bin SHALL be valid in the same cycle as gray (zero added latency).
REQ-023 WIDTH = 1: sequence 0,1,0,... and wrap pulses after every 1->0 (up) or 0->1 (down) step.

Reset
REQ-024 On rst high at a clock edge: gray <= 0, wrap <= 0; bin therefore reads 0.
REQ-025 rst SHALL override load and en in the same cycle; assertion mid-count discards the count.
REQ-026 First counted step after rst release SHALL start from 0.

Structure
REQ-027 Shared package gray_pkg SHALL hold the bin2gray and gray2bin functions (WIDTH-generic) and any width constants.
REQ-028 One sub-module, gray_to_bin (parametrised WIDTH, purely combinational), SHALL produce bin from gray and SHALL be reused for next-state decode.
REQ-029 The sub-module SHALL match the 4-bit table 0000->0000, 0001->0001, 0011->0010, 0010->0011, 0110->0100, ..., 1000->1111.

Verification
REQ-030 WIDTH=4, rst then en=1 up=1 for 16 cycles -> gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 then 0 with wrap=1 exactly once; Hamming distance 1 every step.
REQ-031 WIDTH=4, from reset en=1 up=0 one cycle -> gray=1000, bin=1111, wrap=1; next cycle gray=1001, bin=1110, wrap=0.
REQ-032 load=1 load_bin=1010 with en=1 -> next cycle gray=1111, bin=1010, wrap=0; following en step up -> gray=1110, bin=1011.
REQ-033 rst asserted together with load=1 mid-count at gray=0110 -> next cycle gray=0000, wrap=0; load ignored.
REQ-034 en toggling random with up random over 10k cycles, WIDTH in {1,4,8} -> bin equals scoreboard binary model, gray == bin2gray(bin), wrap matches model.
REQ-035 en=0 for 5 cycles at gray=1101 -> gray stays 1101, bin stays 1001, wrap stays 0.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code conversion helpers and width limits.
package gray_pkg;
    localparam int MAX_WIDTH = 32;

    // Operate at the maximum width; zero-extended inputs convert correctly at any narrower width.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b = g;
        for (int i = MAX_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational reflected-Gray to binary decoder.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    assign bin = WIDTH'(gray2bin(MAX_WIDTH'(gray)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down loadable counter whose only state is a Gray-code register.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);
    logic [WIDTH-1:0] step;
    logic             at_edge;

    // The same decode drives both the bin output and next-state arithmetic.
    gray_to_bin #(.WIDTH(WIDTH)) u_dec (.gray(gray), .bin(bin));

    always_comb begin
        step    = up ? bin + 1'b1 : bin - 1'b1;
        at_edge = up ? &bin : ~|bin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            gray <= WIDTH'(bin2gray(MAX_WIDTH'(load_bin)));
            wrap <= 1'b0;
        end else if (en) begin
            gray <= WIDTH'(bin2gray(MAX_WIDTH'(step)));
            wrap <= at_edge;
        end else begin
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed vectors plus a per-cycle arithmetic model for WIDTH 1, 4 and 8.
module tb_gray_counter;
    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [7:0] lb = '0;
    logic [0:0] g1, b1;
    logic [3:0] g4, b4;
    logic [7:0] g8, b8;
    logic wr1, wr4, wr8;
    int passed = 0, total = 0;
    bit chk_on = 1'b0;
    int mb [3];
    bit mw [3];
    int mod_of [3] = '{2, 16, 256};

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(lb[0:0]), .gray(g1), .bin(b1), .wrap(wr1));
    gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(lb[3:0]), .gray(g4), .bin(b4), .wrap(wr4));
    gray_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(lb), .gray(g8), .bin(b8), .wrap(wr8));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: plain modular arithmetic on the binary count.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mb[k] <= 0;
                mw[k] <= 1'b0;
            end else if (load) begin
                mb[k] <= int'(lb) % mod_of[k];
                mw[k] <= 1'b0;
            end else if (en) begin
                mb[k] <= up ? (mb[k] + 1) % mod_of[k] : (mb[k] + mod_of[k] - 1) % mod_of[k];
                mw[k] <= up ? (mb[k] == mod_of[k] - 1) : (mb[k] == 0);
            end else begin
                mw[k] <= 1'b0;
            end
        end
    end

    task automatic cmp(input int k, input int g, input int b, input int w);
        check($sformatf("w%0d_bin", mod_of[k]), b, mb[k]);
        check($sformatf("w%0d_gray", mod_of[k]), g, mb[k] ^ (mb[k] >> 1));
        check($sformatf("w%0d_wrap", mod_of[k]), w, int'(mw[k]));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, int'(g1), int'(b1), int'(wr1));
            cmp(1, int'(g4), int'(b4), int'(wr4));
            cmp(2, int'(g8), int'(b8), int'(wr8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int prev;

    initial begin
        tick();
        chk_on = 1'b1;
        check("reset_gray", int'(g4), 0);
        check("reset_bin", int'(b4), 0);
        check("reset_wrap", int'(wr4), 0);
        rst = 1'b0; en = 1'b1; up = 1'b1;
        prev = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("seq_gray_%0d", i), int'(g4), exp_seq[i]);
            check($sformatf("seq_hamming_%0d", i), $countones(g4 ^ 4'(prev)), 1);
            check($sformatf("seq_wrap_%0d", i), int'(wr4), (i == 16) ? 1 : 0);
            prev = int'(g4);
        end
        rst = 1'b1; tick();
        rst = 1'b0; en = 1'b1; up = 1'b0; tick();
        check("down_gray", int'(g4), 4'b1000);
        check("down_bin", int'(b4), 4'b1111);
        check("down_wrap", int'(wr4), 1);
        tick();
        check("down2_gray", int'(g4), 4'b1001);
        check("down2_bin", int'(b4), 4'b1110);
        check("down2_wrap", int'(wr4), 0);
        load = 1'b1; lb = 8'b1010; tick();
        check("load_gray", int'(g4), 4'b1111);
        check("load_bin", int'(b4), 4'b1010);
        check("load_wrap", int'(wr4), 0);
        load = 1'b0; up = 1'b1; tick();
        check("after_load_gray", int'(g4), 4'b1110);
        check("after_load_bin", int'(b4), 4'b1011);
        load = 1'b1; lb = 8'd4; tick();
        check("mid_gray", int'(g4), 4'b0110);
        rst = 1'b1; lb = 8'd9; tick();
        check("rst_over_load_gray", int'(g4), 0);
        check("rst_over_load_wrap", int'(wr4), 0);
        rst = 1'b0; load = 1'b1; lb = 8'd15; up = 1'b1; tick();
        check("load_max_wrap", int'(wr4), 0);
        lb = 8'd0; up = 1'b0; tick();
        check("load_zero_wrap", int'(wr4), 0);
        lb = 8'd9; tick();
        check("hold_start_gray", int'(g4), 4'b1101);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gray", int'(g4), 4'b1101);
            check("hold_bin", int'(b4), 4'b1001);
            check("hold_wrap", int'(wr4), 0);
        end
        for (int i = 0; i < 10000; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 499) == 0);
            lb = 8'($urandom_range(0, 255));
            tick();
        end
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
